// File: rtl/iana_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// iana_trace_buffer_if
//
// Bundles the trace-capture, host-readout and stall-handshake signals of the
// IANA trace buffer.
//
//   master : the side that feeds the buffer (trace source and host reader).
//            It drives iana_in, capture_en, clear_in and rd_req.
//   slave  : the trace buffer itself.
//            It drives rd_data, rd_valid, count_out, overflow_out and the
//            stall_enable_out / stall_disable_out pulses.
//
// DEPTH sizes count_out. It must match the DEPTH of the attached buffer.
// ---------------------------------------------------------------------------
interface iana_trace_buffer_if #(
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [127:0]  iana_in;
  logic          capture_en;
  logic          clear_in;
  logic          rd_req;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [CW-1:0] count_out;
  logic          overflow_out;
  logic          stall_enable_out;
  logic          stall_disable_out;

  modport master (
    output iana_in,
    output capture_en,
    output clear_in,
    output rd_req,
    input  rd_data,
    input  rd_valid,
    input  count_out,
    input  overflow_out,
    input  stall_enable_out,
    input  stall_disable_out
  );

  modport slave (
    input  iana_in,
    input  capture_en,
    input  clear_in,
    input  rd_req,
    output rd_data,
    output rd_valid,
    output count_out,
    output overflow_out,
    output stall_enable_out,
    output stall_disable_out
  );
endinterface

// File: rtl/iana_trace_buffer.sv
// ---------------------------------------------------------------------------
// iana_trace_buffer
//
// Circular FIFO of DEPTH 128-bit trace words captured from the CPU's IANA
// port. A host reads each entry out as four 32-bit words, starting with the
// most significant word. A two-state stall FSM tells the CPU to stop issuing
// when the FIFO fills to HI_MARK. It releases the CPU once the host has
// drained the FIFO to LO_MARK.
//
// Ports
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset; its release is synchronised
//            internally
//   bus    : slave side of iana_trace_buffer_if
//     iana_in / capture_en   : trace word and its capture strobe
//     clear_in               : synchronous flush; overrides capture and read
//     rd_req                 : host consumes the current rd_data word
//     rd_data / rd_valid     : current readout word and the non-empty flag
//     count_out              : number of stored entries (0..DEPTH)
//     overflow_out           : sticky; set when a capture is dropped while full
//     stall_enable_out       : one-cycle pulse when entering STALLED
//     stall_disable_out      : one-cycle pulse when returning to RUN
//
// Parameters: DEPTH must be a power of two and at least 8.
// The marks must satisfy LO_MARK < HI_MARK <= DEPTH.
// ---------------------------------------------------------------------------
module iana_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int HI_MARK = 12,
  parameter int LO_MARK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  iana_trace_buffer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HI_C    = CW'(HI_MARK);
  localparam logic [CW-1:0] LO_C    = CW'(LO_MARK);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_STALLED = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Reset release synchroniser.
  // The state registers below are cleared asynchronously by rst_n.
  // Capture, read and flush stay blocked until ready_q rises on the first
  // edge after release. The first capture can therefore land on the second
  // rising edge.
  // -------------------------------------------------------------------------
  logic ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Storage. Its contents are deliberately left unreset.
  // -------------------------------------------------------------------------
  logic [127:0]  mem [DEPTH];

  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [1:0]    word_sel_q, word_sel_d;
  logic          overflow_q, overflow_d;

  state_t        state_q,    state_d;
  logic          stall_en_q, stall_en_d;
  logic          stall_dis_q, stall_dis_d;

  logic          full;
  logic          empty;
  logic          flush;
  logic          wr_fire;
  logic          wr_drop;
  logic          rd_fire;
  logic          pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign flush = ready_q & bus.clear_in;

  // Fullness is judged on the current count, before any pop in the same
  // cycle. A capture while full is dropped even if an entry leaves this
  // cycle.
  assign wr_fire = ready_q & bus.capture_en & ~bus.clear_in & ~full;
  assign wr_drop = ready_q & bus.capture_en & ~bus.clear_in &  full;
  assign rd_fire = ready_q & bus.rd_req     & ~bus.clear_in & ~empty;
  assign pop     = rd_fire & (word_sel_q == 2'd3);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= bus.iana_in;
    end
  end

  // -------------------------------------------------------------------------
  // Pointer / count / word-select next state.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_sel_d = word_sel_q;
    overflow_d = overflow_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      word_sel_d = 2'd0;
      overflow_d = 1'b0;
    end else begin
      if (wr_fire) begin
        // DEPTH is a power of two, so the pointers wrap on their own.
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_fire) begin
        // Steps 0,1,2,3 and then wraps back to 0 on the popping read.
        word_sel_d = word_sel_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // A write and a pop in the same cycle cancel out in the count.
      count_d = count_q + CW'(wr_fire) - CW'(pop);
      if (wr_drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_sel_q <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_sel_q <= word_sel_d;
      overflow_q <= overflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Readout. The head entry is split into four 32-bit words.
  // Word 0 is the most significant.
  // -------------------------------------------------------------------------
  logic [127:0] head_entry;
  logic [31:0]  head_words [4];

  assign head_entry = mem[rd_ptr_q];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign head_words[gi] = head_entry[127 - 32*gi -: 32];
    end
  endgenerate

  // Gated to zero when empty, so the host never sees stale or unwritten RAM.
  assign bus.rd_data      = empty ? 32'd0 : head_words[word_sel_q];
  assign bus.rd_valid     = ~empty;
  assign bus.count_out    = count_q;
  assign bus.overflow_out = overflow_q;

  // -------------------------------------------------------------------------
  // Stall FSM: state register.
  // The pulse flops are updated together with the state, so each pulse
  // appears in the cycle right after the transition edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_en_q  <= 1'b0;
      stall_dis_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_en_q  <= stall_en_d;
      stall_dis_q <= stall_dis_d;
    end
  end

  // Stall FSM: next state. A flush always returns to RUN.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:     if (count_q >= HI_C) state_d = ST_STALLED;
        ST_STALLED: if (count_q <= LO_C) state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  // Stall FSM: outputs.
  // A pulse is raised only on an actual state change. Each change flips the
  // state, so the two pulses can never coincide.
  always_comb begin
    stall_en_d  = (state_q == ST_RUN)     && (state_d == ST_STALLED);
    stall_dis_d = (state_q == ST_STALLED) && (state_d == ST_RUN);
  end

  assign bus.stall_enable_out  = stall_en_q;
  assign bus.stall_disable_out = stall_dis_q;

endmodule

// File: tb/tb_iana_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_iana_trace_buffer
//
// Directed bench for iana_trace_buffer (DEPTH=16, HI_MARK=12, LO_MARK=4).
// Each trace entry e carries the words A000_0000 + 4e + w, for w = 0..3,
// with word 0 the most significant.
// ---------------------------------------------------------------------------
module tb_iana_trace_buffer;

  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;

  iana_trace_buffer_if #(.DEPTH(DEPTH)) bus ();

  iana_trace_buffer #(
    .DEPTH   (DEPTH),
    .HI_MARK (12),
    .LO_MARK (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_bad;
  int en_cnt;
  int dis_cnt;
  int both_cnt;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int e, input int w);
    return 32'hA000_0000 + 32'(e * 4 + w);
  endfunction

  function automatic logic [127:0] ent(input int e);
    return {word(e, 0), word(e, 1), word(e, 2), word(e, 3)};
  endfunction

  // One clock. Outputs are sampled 1 ns after the edge, and stall pulses
  // are tallied at that point.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.stall_enable_out === 1'b1)  en_cnt++;
    if (bus.stall_disable_out === 1'b1) dis_cnt++;
    if (bus.stall_enable_out === 1'b1 && bus.stall_disable_out === 1'b1) both_cnt++;
  endtask

  initial begin
    n_chk = 0; n_bad = 0; en_cnt = 0; dis_cnt = 0; both_cnt = 0;
    rst_n          = 1'b0;
    bus.iana_in    = 128'h00000001_00000002_00000003_00000004;
    bus.capture_en = 1'b1;
    bus.clear_in   = 1'b0;
    bus.rd_req     = 1'b0;

    // Reset state, with capture_en held high the whole time.
    tick(); tick();
    chk("rst_count",    bus.count_out, 0);
    chk("rst_valid",    bus.rd_valid, 0);
    chk("rst_ovf",      bus.overflow_out, 0);
    chk("rst_stall_en", bus.stall_enable_out, 0);
    chk("rst_stall_dis", bus.stall_disable_out, 0);

    // Release mid-cycle: no capture on the first edge, capture on the second.
    #3 rst_n = 1'b1;
    tick();
    chk("sync_edge1_count", bus.count_out, 0);
    tick();
    chk("sync_edge2_count", bus.count_out, 1);
    bus.capture_en = 1'b0;

    // Four-word readout order.
    chk("rd_w0", bus.rd_data, 32'h00000001);
    chk("rd_valid_1", bus.rd_valid, 1);
    bus.rd_req = 1'b1;
    tick(); chk("rd_w1", bus.rd_data, 32'h00000002);
    tick(); chk("rd_w2", bus.rd_data, 32'h00000003);
    tick(); chk("rd_w3", bus.rd_data, 32'h00000004);
    tick();
    chk("rd_valid_after4", bus.rd_valid, 0);
    chk("rd_count_after4", bus.count_out, 0);
    bus.rd_req = 1'b0;

    // Fill to 16. Expect exactly one stall_enable pulse, in the cycle after
    // the count reaches 12.
    en_cnt = 0; dis_cnt = 0;
    bus.capture_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.iana_in = ent(i - 1);
      tick();
      chk($sformatf("fill_count_%0d", i), bus.count_out, i);
      if (i == 12) chk("stall_en_at12", bus.stall_enable_out, 0);
      if (i == 13) chk("stall_en_at13", bus.stall_enable_out, 1);
    end
    chk("fill_en_pulses", en_cnt, 1);

    // A capture while full is dropped and raises the sticky overflow.
    chk("ovf_before", bus.overflow_out, 0);
    bus.iana_in = ent(99);
    tick();
    chk("ovf_set", bus.overflow_out, 1);
    chk("ovf_count", bus.count_out, 16);
    bus.capture_en = 1'b0;

    // Drain 48 words (12 entries), giving one stall_disable pulse at count 4.
    dis_cnt = 0;
    bus.rd_req = 1'b1;
    for (int k = 0; k < 48; k++) begin
      chk($sformatf("drain_w%0d", k), bus.rd_data, word(k / 4, k % 4));
      tick();
    end
    bus.rd_req = 1'b0;
    chk("drain_count", bus.count_out, 4);
    chk("drain_dis_none_yet", dis_cnt, 0);
    tick(); tick(); tick();
    chk("drain_dis_pulses", dis_cnt, 1);
    chk("drain_ovf_sticky", bus.overflow_out, 1);

    // Count 5: a write and the final read of an entry in the same cycle.
    bus.capture_en = 1'b1; bus.iana_in = ent(20);
    tick();
    bus.capture_en = 1'b0;
    chk("wp_count5", bus.count_out, 5);
    bus.rd_req = 1'b1;
    tick(); tick(); tick();
    chk("wp_w3", bus.rd_data, word(12, 3));
    bus.capture_en = 1'b1; bus.iana_in = ent(21);
    tick();
    bus.capture_en = 1'b0; bus.rd_req = 1'b0;
    chk("wp_count_same", bus.count_out, 5);
    chk("wp_wordsel0", bus.rd_data, word(13, 0));

    // Fill back into STALLED, then drain to 10 entries.
    en_cnt = 0; dis_cnt = 0;
    bus.capture_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.iana_in = ent(30 + i);
      tick();
    end
    bus.capture_en = 1'b0;
    chk("st_count12", bus.count_out, 12);
    tick();
    chk("st_en_pulse", en_cnt, 1);
    bus.rd_req = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    bus.rd_req = 1'b0;
    chk("st_count10", bus.count_out, 10);
    chk("st_no_dis", dis_cnt, 0);
    chk("st_ovf_still", bus.overflow_out, 1);

    // A clear together with a capture and a read: the clear wins.
    bus.clear_in = 1'b1; bus.capture_en = 1'b1; bus.rd_req = 1'b1; bus.iana_in = ent(50);
    tick();
    bus.clear_in = 1'b0; bus.capture_en = 1'b0; bus.rd_req = 1'b0;
    chk("clr_count", bus.count_out, 0);
    chk("clr_ovf", bus.overflow_out, 0);
    chk("clr_valid", bus.rd_valid, 0);
    chk("clr_dis_pulse", bus.stall_disable_out, 1);
    tick();
    chk("clr_dis_single", dis_cnt, 1);

    // A read request while empty is ignored.
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("empty_rd_count", bus.count_out, 0);
    bus.capture_en = 1'b1; bus.iana_in = ent(40);
    tick();
    bus.capture_en = 1'b0;
    chk("empty_rd_w0", bus.rd_data, word(40, 0));

    // Reset asserted mid-entry, with word_sel at 2.
    bus.rd_req = 1'b1;
    tick(); tick();
    bus.rd_req = 1'b0;
    chk("mid_w2", bus.rd_data, word(40, 2));
    dis_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", bus.count_out, 0);
    chk("mid_rst_valid", bus.rd_valid, 0);
    chk("mid_rst_ovf", bus.overflow_out, 0);
    chk("mid_rst_en", bus.stall_enable_out, 0);
    chk("mid_rst_dis", bus.stall_disable_out, 0);
    bus.capture_en = 1'b1; bus.iana_in = ent(41);
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("mid_rel_edge1", bus.count_out, 0);
    tick();
    bus.capture_en = 1'b0;
    chk("mid_rel_edge2", bus.count_out, 1);
    chk("mid_new_w0", bus.rd_data, word(41, 0));
    chk("mid_no_dis", dis_cnt, 0);
    chk("pulse_exclusive", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
